// File: rtl/disp_seq.sv
// Display sequencer for the guessing game's four 7-segment digits.
// Turns short game commands into timed messages and a blinking win banner.
module disp_seq #(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_val,
  input  logic [7:0] base_val,
  output logic [4:0] d3,
  output logic [4:0] d2,
  output logic [4:0] d1,
  output logic [4:0] d0,
  output logic       busy
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  localparam logic [4:0] DIG_H     = 5'd20;
  localparam logic [4:0] DIG_I     = 5'd21;
  localparam logic [4:0] DIG_L     = 5'd22;
  localparam logic [4:0] DIG_O     = 5'd23;
  localparam logic [4:0] DIG_MINUS = 5'd30;
  localparam logic [4:0] DIG_BLANK = 5'd31;
  localparam logic [19:0] ALL_BLANK = {4{DIG_BLANK}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_WIN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NUM = 2'd0,
    OP_HI  = 2'd1,
    OP_LO  = 2'd2,
    OP_WIN = 2'd3
  } op_e;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [7:0]      val_q, val_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_on_q, phase_on_d;
  logic [19:0]     digits_q, digits_d;
  logic            busy_q, busy_d;
  logic            accept;
  op_e             cmd_op_e;

  // Sign-magnitude rendering; -128 keeps magnitude 0x80 through the negate.
  function automatic logic [19:0] render_num(input logic [7:0] v);
    logic [7:0] mag;
    logic [4:0] r3, r1;
    mag = v[7] ? (~v + 8'd1) : v;
    r3  = v[7] ? DIG_MINUS : DIG_BLANK;
    r1  = (mag[7:4] == 4'd0) ? DIG_BLANK : {1'b0, mag[7:4]};
    return {r3, DIG_BLANK, r1, {1'b0, mag[3:0]}};
  endfunction

  always_comb begin
    cmd_ready = (state_q != S_HOLD);
  end

  assign accept   = cmd_valid & cmd_ready;
  assign cmd_op_e = op_e'(cmd_op);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NUM;
      val_q       <= 8'd0;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b0;
      digits_q    <= ALL_BLANK;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      val_q       <= val_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_on_q  <= phase_on_d;
      digits_q    <= digits_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: WIN accepts commands exactly like IDLE, HOLD is deaf.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    val_d       = val_q;
    hold_cnt_d  = hold_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_on_d  = phase_on_q;

    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_IDLE, S_WIN: begin
        if (accept) begin
          op_d        = cmd_op_e;
          val_d       = cmd_val;
          hold_cnt_d  = '0;
          blink_cnt_d = '0;
          phase_on_d  = 1'b1;
          state_d     = (cmd_op_e == OP_WIN) ? S_WIN : S_HOLD;
        end else if (state_q == S_WIN) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_on_d  = ~phase_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Digits are computed from the upcoming state so they land with the transition.
  always_comb begin
    digits_d = ALL_BLANK;
    busy_d   = (state_d == S_HOLD);
    case (state_d)
      S_IDLE: digits_d = render_num(base_val);
      S_HOLD: begin
        case (op_d)
          OP_HI:   digits_d = {DIG_BLANK, DIG_BLANK, DIG_H, DIG_I};
          OP_LO:   digits_d = {DIG_BLANK, DIG_BLANK, DIG_L, DIG_O};
          default: digits_d = render_num(val_d);
        endcase
      end
      S_WIN:   digits_d = phase_on_d ? render_num(val_d) : ALL_BLANK;
      default: digits_d = ALL_BLANK;
    endcase
  end

  assign d3   = digits_q[19:15];
  assign d2   = digits_q[14:10];
  assign d1   = digits_q[9:5];
  assign d0   = digits_q[4:0];
  assign busy = busy_q;

endmodule

// File: tb/tb_disp_seq.sv
// Bench for disp_seq: directed scenarios plus a randomized run, all checked
// against a cycle-level behavioural model of the display rules.
module tb_disp_seq;

  localparam int H = 4;
  localparam int B = 2;
  localparam logic [19:0] BLANK = {4{5'd31}};

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_val;
  logic [7:0] base_val;
  logic [4:0] d3, d2, d1, d0;
  logic       busy;
  logic [19:0] dig;

  int total = 0;
  int bad   = 0;

  // Model: mode 0=idle, 1=hold, 2=win
  int         mMode     = 0;
  int         mHoldLeft = 0;
  int         mWinAge   = 0;
  int         mOp       = 0;
  logic [7:0] mVal      = 8'd0;
  logic [7:0] mBase     = 8'd0;
  logic       mBlank    = 1'b1;
  logic [19:0] expDig;
  logic        expBusy;
  logic        expReady;

  always #5 clk = ~clk;

  assign dig = {d3, d2, d1, d0};

  disp_seq #(.HOLD_CYCLES(H), .BLINK_CYCLES(B)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_val  (cmd_val),
    .base_val (base_val),
    .d3       (d3),
    .d2       (d2),
    .d1       (d1),
    .d0       (d0),
    .busy     (busy)
  );

  function automatic logic [19:0] refRender(input logic [7:0] v);
    int sv, mag, hi, lo;
    sv  = int'($signed(v));
    mag = (sv < 0) ? -sv : sv;
    hi  = mag / 16;
    lo  = mag % 16;
    return {(sv < 0) ? 5'd30 : 5'd31, 5'd31, (hi == 0) ? 5'd31 : 5'(hi), 5'(lo)};
  endfunction

  // Advances the model on the current inputs, then the DUT by one edge.
  task automatic tick();
    if (rst) begin
      mMode  = 0;
      mBlank = 1'b1;
    end else begin
      mBlank = 1'b0;
      if (cmd_valid && mMode != 1) begin
        mOp       = int'(cmd_op);
        mVal      = cmd_val;
        mMode     = (cmd_op == 2'd3) ? 2 : 1;
        mHoldLeft = H;
        mWinAge   = 0;
      end else if (mMode == 1) begin
        mHoldLeft--;
        if (mHoldLeft == 0) mMode = 0;
      end else if (mMode == 2) begin
        mWinAge++;
      end
      mBase = base_val;
    end
    @(posedge clk);
    #1;
    expBusy  = (mMode == 1);
    expReady = (mMode != 1);
    if (mBlank) expDig = BLANK;
    else if (mMode == 0) expDig = refRender(mBase);
    else if (mMode == 1) begin
      if (mOp == 1)      expDig = {5'd31, 5'd31, 5'd20, 5'd21};
      else if (mOp == 2) expDig = {5'd31, 5'd31, 5'd22, 5'd23};
      else               expDig = refRender(mVal);
    end else begin
      expDig = (((mWinAge / B) % 2) == 0) ? refRender(mVal) : BLANK;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_val = 8'd0; base_val = 8'h05;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (dig !== BLANK) begin bad++; $display("[TB] FAIL reset_digits: got %h want %h", dig, BLANK); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    end
    rst = 1'b0;
    tick();
    total++;
    if (dig !== {5'd31, 5'd31, 5'd31, 5'd5}) begin bad++; $display("[TB] FAIL idle_base: got %h want %h", dig, {5'd31, 5'd31, 5'd31, 5'd5}); end
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_flags: got ready=%b busy=%b want ready=1 busy=0", cmd_ready, busy); end
  endtask

  task automatic test_negative_render();
    base_val = 8'h80;
    tick();
    total++;
    if (dig !== {5'd30, 5'd31, 5'd8, 5'd0}) begin bad++; $display("[TB] FAIL neg128: got %h want %h", dig, {5'd30, 5'd31, 5'd8, 5'd0}); end
    base_val = 8'hFF;
    tick();
    total++;
    if (dig !== {5'd30, 5'd31, 5'd31, 5'd1}) begin bad++; $display("[TB] FAIL neg1: got %h want %h", dig, {5'd30, 5'd31, 5'd31, 5'd1}); end
  endtask

  task automatic test_hi_hold();
    base_val = 8'h09;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_val = 8'h55;
    for (int i = 0; i < H; i++) begin
      tick();
      cmd_op = 2'd2;
      total++;
      if (dig !== {5'd31, 5'd31, 5'd20, 5'd21}) begin bad++; $display("[TB] FAIL hi_digits[%0d]: got %h want %h", i, dig, {5'd31, 5'd31, 5'd20, 5'd21}); end
      total++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL hi_flags[%0d]: got busy=%b ready=%b want busy=1 ready=0", i, busy, cmd_ready); end
    end
    tick();
    total++;
    if (dig !== refRender(8'h09) || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL hi_release: got %h busy=%b ready=%b want %h busy=0 ready=1", dig, busy, cmd_ready, refRender(8'h09));
    end
    tick();
    cmd_valid = 1'b0;
    total++;
    if (dig !== {5'd31, 5'd31, 5'd22, 5'd23} || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL lo_after_hi: got %h busy=%b want %h busy=1", dig, busy, {5'd31, 5'd31, 5'd22, 5'd23});
    end
    for (int i = 0; i < H; i++) begin
      tick();
      total++;
      if (dig !== expDig || busy !== expBusy) begin bad++; $display("[TB] FAIL lo_drain[%0d]: got %h busy=%b want %h busy=%b", i, dig, busy, expDig, expBusy); end
    end
  endtask

  task automatic test_num_revert();
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_val = 8'h3C;
    for (int i = 0; i < H; i++) begin
      tick();
      cmd_valid = 1'b0;
      if (i == 1) base_val = 8'h02;
      total++;
      if (dig !== {5'd31, 5'd31, 5'd3, 5'd12} || busy !== 1'b1) begin
        bad++; $display("[TB] FAIL num_hold[%0d]: got %h busy=%b want %h busy=1", i, dig, busy, {5'd31, 5'd31, 5'd3, 5'd12});
      end
    end
    tick();
    total++;
    if (dig !== {5'd31, 5'd31, 5'd31, 5'd2} || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL num_revert: got %h busy=%b want %h busy=0", dig, busy, {5'd31, 5'd31, 5'd31, 5'd2});
    end
  endtask

  task automatic test_win_blink();
    logic [19:0] onDig;
    onDig = {5'd31, 5'd31, 5'd31, 5'd7};
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_val = 8'h07;
    for (int i = 0; i < 5; i++) begin
      tick();
      cmd_valid = 1'b0;
      total++;
      if (dig !== ((i == 2 || i == 3) ? BLANK : onDig) || busy !== 1'b0) begin
        bad++; $display("[TB] FAIL win_phase[%0d]: got %h busy=%b want %h busy=0", i, dig, busy, (i == 2 || i == 3) ? BLANK : onDig);
      end
    end
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_val = 8'h01;
    tick();
    cmd_valid = 1'b0;
    total++;
    if (dig !== {5'd31, 5'd31, 5'd31, 5'd1} || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL win_preempt: got %h busy=%b want %h busy=1", dig, busy, {5'd31, 5'd31, 5'd31, 5'd1});
    end
    for (int i = 0; i < H; i++) tick();
  endtask

  task automatic test_reset_mid_hold();
    base_val = 8'h04;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_val = 8'h42;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd3; cmd_val = 8'h66;
    tick();
    rst = 1'b0; cmd_valid = 1'b0;
    total++;
    if (dig !== BLANK || busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_hold: got %h busy=%b want %h busy=0", dig, busy, BLANK); end
    tick();
    total++;
    if (dig !== refRender(8'h04) || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_no_accept: got %h busy=%b want %h busy=0", dig, busy, refRender(8'h04));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_val   = 8'($urandom);
      if ($urandom_range(0, 4) == 0) base_val = 8'($urandom);
      tick();
      total++;
      if (dig !== expDig) begin bad++; $display("[TB] FAIL rand_digits[%0d]: got %h want %h", i, dig, expDig); end
      total++;
      if (busy !== expBusy || cmd_ready !== expReady) begin
        bad++; $display("[TB] FAIL rand_flags[%0d]: got busy=%b ready=%b want busy=%b ready=%b", i, busy, cmd_ready, expBusy, expReady);
      end
    end
    rst = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_val = 8'd0; base_val = 8'd0;
    #2;
    test_reset();
    test_negative_render();
    test_hi_hold();
    test_num_revert();
    test_win_blink();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
